// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage program-counter generator.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_TRAP   = 3'd0,
        SEL_BRANCH = 3'd1,
        SEL_JUMP   = 3'd2,
        SEL_SEQ    = 3'd3,
        SEL_HOLD   = 3'd4
    } pc_sel_e;

endpackage

// File: rtl/pc_next_sel.sv
// Prioritised next-address mux with target alignment check.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned IALIGN = 4
) (
    input  logic            run,
    input  logic            adv,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            PCsel,
    input  logic [XLEN-1:0] branch,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_pc,
    input  logic [XLEN-1:0] cur_pc,
    output logic [XLEN-1:0] nextpc,
    output pc_sel_e         sel,
    output logic            misalign
);

    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(IALIGN - 1);
    localparam logic [XLEN-1:0] STEP     = XLEN'(IALIGN);

    logic branch_bad;
    logic jump_bad;

    assign branch_bad = (branch & LOW_MASK) != '0;
    assign jump_bad   = (jump_pc & LOW_MASK) != '0;

    // A misaligned branch/jump blocks every lower-priority source that cycle.
    always_comb begin
        sel      = SEL_HOLD;
        nextpc   = cur_pc;
        misalign = 1'b0;
        if (trap_en) begin
            sel    = SEL_TRAP;
            nextpc = trap_pc & ~LOW_MASK;
        end else if (run && PCsel) begin
            if (branch_bad) begin
                misalign = 1'b1;
            end else begin
                sel    = SEL_BRANCH;
                nextpc = branch;
            end
        end else if (run && jump_en) begin
            if (jump_bad) begin
                misalign = 1'b1;
            end else begin
                sel    = SEL_JUMP;
                nextpc = jump_pc;
            end
        end else if (adv) begin
            sel    = SEL_SEQ;
            nextpc = cur_pc + STEP;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch program counter: PC register, BOOT/RUN/HALT control and the
// valid/ready request towards instruction memory.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int unsigned     IALIGN    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Stop_en,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            PCsel,
    input  logic [XLEN-1:0] branch,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_pc,
    input  logic            halt,
    input  logic            resume,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] cur_pc,
    output logic [XLEN-1:0] nextpc,
    output logic            misalign_err
);

    pc_state_e state;
    pc_state_e state_nxt;
    pc_sel_e   sel;
    logic      misalign;
    logic      run;
    logic      adv;

    assign run = (state == RUN);
    assign adv = run && req_valid && req_ready && !Stop_en;

    pc_next_sel #(
        .XLEN  (XLEN),
        .IALIGN(IALIGN)
    ) u_next_sel (
        .run     (run),
        .adv     (adv),
        .trap_en (trap_en),
        .trap_pc (trap_pc),
        .PCsel   (PCsel),
        .branch  (branch),
        .jump_en (jump_en),
        .jump_pc (jump_pc),
        .cur_pc  (cur_pc),
        .nextpc  (nextpc),
        .sel     (sel),
        .misalign(misalign)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // halt has priority over resume while halted.
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (halt) state_nxt = HALT;
            HALT:    if (resume && !halt) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_pc       <= RESET_VEC;
            req_valid    <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            if (sel != SEL_HOLD) begin
                cur_pc <= nextpc;
            end
            req_valid    <= (state_nxt == RUN);
            misalign_err <= misalign;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed vector table, hand sequences and random
// stimulus against an abstract reference model (IALIGN 4 and 2 instances).
module tb_pc_gen;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stop_en, trap_en, pcsel, jump_en, halt, resume, req_ready;
    logic [31:0] trap_pc, branch, jump_pc;

    logic        v4, e4, v2, e2;
    logic [31:0] pc4, np4, pc2, np2;

    int n_checks = 0;
    int n_errors = 0;

    int unsigned IA [2] = '{4, 2};
    logic [31:0] m_pc   [2];
    int          m_mode [2];
    bit          m_err  [2];

    always #5 clk = ~clk;

    pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .IALIGN(4)) dut4 (
        .clk(clk), .rst(rst_n), .Stop_en(stop_en), .trap_en(trap_en), .trap_pc(trap_pc),
        .PCsel(pcsel), .branch(branch), .jump_en(jump_en), .jump_pc(jump_pc),
        .halt(halt), .resume(resume), .req_valid(v4), .req_ready(req_ready),
        .cur_pc(pc4), .nextpc(np4), .misalign_err(e4)
    );

    pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .IALIGN(2)) dut2 (
        .clk(clk), .rst(rst_n), .Stop_en(stop_en), .trap_en(trap_en), .trap_pc(trap_pc),
        .PCsel(pcsel), .branch(branch), .jump_en(jump_en), .jump_pc(jump_pc),
        .halt(halt), .resume(resume), .req_valid(v2), .req_ready(req_ready),
        .cur_pc(pc2), .nextpc(np2), .misalign_err(e2)
    );

    typedef struct {
        logic        stop;
        logic        trap;
        logic [31:0] tpc;
        logic        bsel;
        logic [31:0] btgt;
        logic        jmp;
        logic [31:0] jtgt;
        logic        hlt;
        logic        res;
        logic        rdy;
        logic [31:0] exp_pc;
        logic        exp_valid;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic stop, logic trap, logic [31:0] tpc, logic bsel,
                                logic [31:0] btgt, logic jmp, logic [31:0] jtgt,
                                logic hlt, logic res, logic rdy,
                                logic [31:0] exp_pc, logic exp_valid, logic exp_err);
        vec_t v;
        v.stop = stop; v.trap = trap; v.tpc = tpc; v.bsel = bsel; v.btgt = btgt;
        v.jmp = jmp; v.jtgt = jtgt; v.hlt = hlt; v.res = res; v.rdy = rdy;
        v.exp_pc = exp_pc; v.exp_valid = exp_valid; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stop_en = 0; trap_en = 0; trap_pc = 0; pcsel = 0; branch = 0;
        jump_en = 0; jump_pc = 0; halt = 0; resume = 0; req_ready = 0;
    endtask

    task automatic apply(input vec_t v);
        stop_en = v.stop; trap_en = v.trap; trap_pc = v.tpc; pcsel = v.bsel; branch = v.btgt;
        jump_en = v.jmp; jump_pc = v.jtgt; halt = v.hlt; resume = v.res; req_ready = v.rdy;
    endtask

    // Reset held over two edges, released mid-cycle; model follows.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 32'h0; m_mode[k] = M_BOOT; m_err[k] = 0;
        end
    endtask

    // Abstract model: pick first requesting source in priority order.
    function automatic void predict(input int k, output logic [31:0] np, output bit err,
                                    output int mode_n);
        int unsigned ia;
        logic [31:0] tgt;
        ia = IA[k];
        np = m_pc[k]; err = 0; mode_n = m_mode[k];
        if (trap_en) begin
            np = trap_pc - (trap_pc % ia);
        end else if (m_mode[k] == M_RUN && (pcsel || jump_en)) begin
            tgt = pcsel ? branch : jump_pc;
            if (tgt % ia != 0) err = 1;
            else np = tgt;
        end else if (m_mode[k] == M_RUN && req_ready && !stop_en) begin
            np = m_pc[k] + ia;
        end
        if (m_mode[k] == M_BOOT) mode_n = M_RUN;
        else if (m_mode[k] == M_RUN && halt) mode_n = M_HALT;
        else if (m_mode[k] == M_HALT && resume && !halt) mode_n = M_RUN;
    endfunction

    task automatic model_step();
        logic [31:0] np [2];
        bit          er [2];
        int          mn [2];
        #1;
        for (int k = 0; k < 2; k++) predict(k, np[k], er[k], mn[k]);
        check("nextpc4", np4, np[0]);
        check("nextpc2", np2, np[1]);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = np[k]; m_err[k] = er[k]; m_mode[k] = mn[k];
        end
        check("cur_pc4", pc4, m_pc[0]);
        check("valid4",  v4,  m_mode[0] == M_RUN);
        check("err4",    e4,  m_err[0]);
        check("cur_pc2", pc2, m_pc[1]);
        check("valid2",  v2,  m_mode[1] == M_RUN);
        check("err2",    e2,  m_err[1]);
    endtask

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        t = $urandom;
        case ($urandom_range(3, 0))
            0:       t = t & 32'h0000_00FC;
            1:       t = 32'hFFFF_FFF8 | (t & 32'h7);
            2:       t = t & 32'hFFFF_FFFC;
            default: t = t & 32'h0000_0FFF;
        endcase
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        //         stop trap tpc          bsel btgt  jmp jtgt  hlt res rdy  exp_pc        v  e
        tbl.push_back(mk(0, 0, 0,            0, 0,    0, 0,    0, 0, 1,  32'd0,        1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,    0, 0,    0, 0, 1,  32'd4,        1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,    0, 0,    0, 0, 1,  32'd8,        1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,    0, 0,    0, 0, 0,  32'd8,        1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,    0, 0,    0, 0, 0,  32'd8,        1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,    0, 0,    0, 0, 0,  32'd8,        1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,    0, 0,    0, 0, 1,  32'd12,       1, 0));
        tbl.push_back(mk(1, 0, 0,            1, 100,  1, 200,  0, 0, 1,  32'd100,      1, 0));
        tbl.push_back(mk(1, 1, 32'h81,       1, 100,  1, 200,  0, 0, 1,  32'h80,       1, 0));
        tbl.push_back(mk(0, 0, 0,            1, 102,  0, 0,    0, 0, 1,  32'h80,       1, 1));
        tbl.push_back(mk(0, 0, 0,            0, 0,    0, 0,    0, 0, 0,  32'h80,       1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,    1, 16,   0, 0, 1,  32'd16,       1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,    0, 0,    1, 0, 0,  32'd16,       0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,    0, 0,    0, 0, 1,  32'd16,       0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,    0, 0,    0, 0, 1,  32'd16,       0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,    0, 0,    0, 0, 1,  32'd16,       0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,    0, 0,    0, 0, 1,  32'd16,       0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,    0, 0,    0, 1, 1,  32'd16,       1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,    0, 0,    0, 0, 1,  32'd20,       1, 0));
        tbl.push_back(mk(0, 1, 32'hFFFFFFFF, 0, 0,    0, 0,    0, 0, 1,  32'hFFFFFFFC, 1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,    0, 0,    0, 0, 1,  32'd0,        1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,    0, 0,    0, 0, 1,  32'd4,        1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,    0, 0,    1, 0, 0,  32'd4,        0, 0));
        tbl.push_back(mk(0, 1, 32'h55,       0, 0,    0, 0,    0, 0, 1,  32'h54,       0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,    1, 64,   0, 0, 1,  32'h54,       0, 0));

        // Directed table on the IALIGN=4 instance.
        do_reset();
        #1;
        check("reset_pc", pc4, 32'h0);
        check("reset_valid", v4, 1'b0);
        check("reset_err", e4, 1'b0);
        check("boot_nextpc", np4, 32'h0);
        foreach (tbl[i]) begin
            apply(tbl[i]);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_pc", i), pc4, tbl[i].exp_pc);
            check($sformatf("tbl%0d_valid", i), v4, tbl[i].exp_valid);
            check($sformatf("tbl%0d_err", i), e4, tbl[i].exp_err);
        end

        // Same misaligned branch on both alignments.
        do_reset();
        req_ready = 0;
        @(posedge clk);
        #1;
        pcsel = 1; branch = 32'd102;
        @(posedge clk);
        #1;
        check("mis4_pc", pc4, 32'd0);
        check("mis4_err", e4, 1'b1);
        check("mis2_pc", pc2, 32'd102);
        check("mis2_err", e2, 1'b0);
        pcsel = 0;
        @(posedge clk);
        #1;
        check("mis4_pulse_end", e4, 1'b0);
        check("mis4_pc_hold", pc4, 32'd0);

        // Asynchronous reset mid-stream.
        jump_en = 1; jump_pc = 32'd40;
        @(posedge clk);
        #1;
        jump_en = 0;
        check("pre_rst_pc", pc4, 32'd40);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc4", pc4, 32'h0);
        check("async_rst_valid4", v4, 1'b0);
        check("async_rst_pc2", pc2, 32'h0);

        // Random stimulus against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            stop_en   = ($urandom_range(99, 0) < 25);
            trap_en   = ($urandom_range(99, 0) < 5);
            trap_pc   = rand_tgt() | ($urandom & 32'h3);
            pcsel     = ($urandom_range(99, 0) < 10);
            branch    = rand_tgt() | (($urandom_range(3, 0) == 0) ? ($urandom & 32'h3) : 32'h0);
            jump_en   = ($urandom_range(99, 0) < 10);
            jump_pc   = rand_tgt() | (($urandom_range(3, 0) == 0) ? ($urandom & 32'h3) : 32'h0);
            halt      = ($urandom_range(99, 0) < 5);
            resume    = ($urandom_range(99, 0) < 25);
            req_ready = ($urandom_range(99, 0) < 70);
            model_step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
